// File: rtl/alu_req_issuer_pkg.sv
// Shared definitions for the ALU request issuer: widths, ALU opcodes
// and the issuer state encoding.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_NOP = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } issuer_state_e;

  // Opcodes 4..7 have no ALU meaning; only 0..3 may be issued.
  function automatic logic op_defined(logic [OP_W-1:0] op);
    return !op[OP_W-1];
  endfunction

endpackage

// File: rtl/alu_req_issuer_if.sv
// Command / ALU / response bundle for the issuer.
// master: the issuer side. slave: the environment (upstream, ALU, downstream).
interface alu_req_issuer_if;
  import alu_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [OP_W-1:0]   cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic [OP_W-1:0]   alu_opcode;
  logic [DATA_W-1:0] alu_data_a;
  logic [DATA_W-1:0] alu_data_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_valid;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [OP_W-1:0]   rsp_op;
  logic              rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_valid, rsp_ready,
    output cmd_ready, alu_opcode, alu_data_a, alu_data_b,
           rsp_valid, rsp_result, rsp_op, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_result, alu_valid, rsp_ready,
    input  cmd_ready, alu_opcode, alu_data_a, alu_data_b,
           rsp_valid, rsp_result, rsp_op, rsp_err
  );

endinterface

// File: rtl/alu_req_issuer.sv
// ALU request issuer: accepts one command, issues it to a registered ALU,
// waits (bounded) for the result and holds a response until handshaken.
// Optional statistics counters are built when ALU_REQ_ISSUER_STATS_EN is defined.
module alu_req_issuer
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_req_issuer_if.master   bus
`ifdef ALU_REQ_ISSUER_STATS_EN
  ,
  output logic [15:0]        stat_cmds,
  output logic [15:0]        stat_errs
`endif
);

  localparam logic [3:0] TO_CNT = 4'(TIMEOUT_CYCLES);

  issuer_state_e     state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              err_q, err_d;

  // State and captured command/response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // Next-state, register updates and all outputs.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    res_d          = res_q;
    err_d          = err_q;
    bus.cmd_ready  = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.rsp_result = res_q;
    bus.rsp_op     = op_q;
    bus.rsp_err    = err_q;
    // Idle ALU inputs make it compute a harmless zero.
    bus.alu_opcode = OP_NOP;
    bus.alu_data_a = '0;
    bus.alu_data_b = '0;
    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          op_d  = bus.cmd_op;
          a_d   = bus.cmd_a;
          b_d   = bus.cmd_b;
          res_d = '0;
          if (op_defined(bus.cmd_op)) begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end else begin
            // Undefined op never touches the ALU: answer with an error at once.
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        bus.alu_opcode = op_q;
        bus.alu_data_a = a_q;
        bus.alu_data_b = b_q;
        cnt_d          = '0;
        state_d        = S_WAIT;
      end
      S_WAIT: begin
        bus.alu_opcode = op_q;
        bus.alu_data_a = a_q;
        bus.alu_data_b = b_q;
        if (bus.alu_valid) begin
          res_d   = bus.alu_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == TO_CNT) begin
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ALU_REQ_ISSUER_STATS_EN
  // Saturating counts of accepted commands and error responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cmds <= '0;
      stat_errs <= '0;
    end else begin
      if (state_q == S_IDLE && bus.cmd_valid && stat_cmds != 16'hFFFF)
        stat_cmds <= stat_cmds + 16'd1;
      if (state_q == S_RESP && bus.rsp_ready && err_q && stat_errs != 16'hFFFF)
        stat_errs <= stat_errs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_req_issuer.sv
// Directed bench for alu_req_issuer; the bench itself plays upstream,
// ALU (driving alu_valid/alu_result with hand-computed values) and downstream.
module tb_alu_req_issuer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  alu_req_issuer_if bus();

`ifdef ALU_REQ_ISSUER_STATS_EN
  logic [15:0] stat_cmds, stat_errs;
`endif

  alu_req_issuer #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
`ifdef ALU_REQ_ISSUER_STATS_EN
    ,
    .stat_cmds (stat_cmds),
    .stat_errs (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; sample/drive 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for exactly one accepting edge.
  task automatic accept(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Edges after acceptance until rsp_valid is seen; 99 if it never comes.
  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.rsp_valid) n = 99;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b, res;
    logic       err;
  } vec_t;

  initial begin
    int   n;
    int   bad;
    vec_t v[4];

    bus.cmd_valid  = 1'b0;
    bus.cmd_op     = '0;
    bus.cmd_a      = '0;
    bus.cmd_b      = '0;
    bus.alu_valid  = 1'b0;
    bus.alu_result = '0;
    bus.rsp_ready  = 1'b1;

    // Reset values.
    tick(); tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_rsp_op", bus.rsp_op, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_alu_opcode", bus.alu_opcode, 3'b111);
    chk("rst_alu_ab", {bus.alu_data_a, bus.alu_data_b}, 0);
    rst_n = 1'b1;
    tick();

    // ADD 12+34: response in cycle 3 counting the accept cycle as 0,
    // i.e. two edges after the accepting edge.
    bus.alu_valid  = 1'b1;
    bus.alu_result = 8'h46;
    accept(3'd0, 8'h12, 8'h34);
    chk("add_issue_op", bus.alu_opcode, 3'd0);
    chk("add_issue_ab", {bus.alu_data_a, bus.alu_data_b}, 16'h1234);
    chk("add_issue_cmd_ready", bus.cmd_ready, 0);
    wait_rsp(n);
    chk("add_latency", n, 2);
    chk("add_result", bus.rsp_result, 8'h46);
    chk("add_op", bus.rsp_op, 3'd0);
    chk("add_err", bus.rsp_err, 0);
    tick();
    chk("add_back_idle", bus.cmd_ready, 1);

    // Undefined op 5: never issued, error response on the next cycle.
    bus.cmd_op = 3'd5; bus.cmd_a = 8'hFF; bus.cmd_b = 8'h01;
    chk("undef_idle_opcode", bus.alu_opcode, 3'b111);
    accept(3'd5, 8'hFF, 8'h01);
    chk("undef_rsp_valid", bus.rsp_valid, 1);
    chk("undef_result", bus.rsp_result, 0);
    chk("undef_err", bus.rsp_err, 1);
    chk("undef_op", bus.rsp_op, 3'd5);
    chk("undef_opcode", bus.alu_opcode, 3'b111);
    tick();
    chk("undef_after_opcode", bus.alu_opcode, 3'b111);

    // Timeout: no alu_valid, ISSUE then 4 WAIT cycles -> RESP 5 edges after accept.
    bus.alu_valid = 1'b0;
    accept(3'd2, 8'hF0, 8'h3C);
    wait_rsp(n);
    chk("to_latency", n, 5);
    chk("to_err", bus.rsp_err, 1);
    chk("to_result", bus.rsp_result, 0);
    chk("to_op", bus.rsp_op, 3'd2);
    tick();

    // Back-pressure: SUB 10-01 stalled 5 cycles with a second command queued.
    bus.alu_valid  = 1'b1;
    bus.alu_result = 8'h0F;
    bus.rsp_ready  = 1'b0;
    accept(3'd1, 8'h10, 8'h01);
    bus.cmd_op = 3'd3; bus.cmd_a = 8'h0A; bus.cmd_b = 8'h50;
    bus.cmd_valid = 1'b1;
    chk("sub_issue_op", bus.alu_opcode, 3'd1);
    wait_rsp(n);
    chk("sub_latency", n, 2);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'h0F || bus.rsp_op !== 3'd1 ||
          bus.rsp_err !== 1'b0 || bus.cmd_ready !== 1'b0) bad++;
      tick();
    end
    chk("stall_stable_bad_cycles", bad, 0);
    chk("stall_result", bus.rsp_result, 8'h0F);
    bus.rsp_ready  = 1'b1;
    bus.alu_result = 8'h5A;
    tick();
    chk("queued_ready_after_hs", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("queued_issue_op", bus.alu_opcode, 3'd3);
    chk("queued_issue_ab", {bus.alu_data_a, bus.alu_data_b}, 16'h0A50);
    wait_rsp(n);
    chk("queued_latency", n, 2);
    chk("queued_result", bus.rsp_result, 8'h5A);
    chk("queued_op", bus.rsp_op, 3'd3);
    tick();

    // Reset during WAIT abandons the command.
    bus.alu_valid = 1'b0;
    accept(3'd0, 8'h01, 8'h02);
    tick();
    chk("wait_opcode_held", bus.alu_opcode, 3'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rstw_cmd_ready", bus.cmd_ready, 1);
    chk("rstw_rsp_valid", bus.rsp_valid, 0);
    chk("rstw_alu_opcode", bus.alu_opcode, 3'b111);
`ifdef ALU_REQ_ISSUER_STATS_EN
    chk("rstw_stat_cmds", stat_cmds, 0);
    chk("rstw_stat_errs", stat_errs, 0);
`endif
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid !== 1'b0) bad++;
      tick();
    end
    chk("rstw_no_response", bad, 0);

    // Three valid commands and one undefined op.
    v[0] = '{op: 3'd0, a: 8'h03, b: 8'h04, res: 8'h07, err: 1'b0};
    v[1] = '{op: 3'd2, a: 8'h0F, b: 8'h3C, res: 8'h0C, err: 1'b0};
    v[2] = '{op: 3'd6, a: 8'h11, b: 8'h22, res: 8'h00, err: 1'b1};
    v[3] = '{op: 3'd3, a: 8'h01, b: 8'h02, res: 8'h03, err: 1'b0};
    bus.alu_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.alu_result = v[i].res;
      accept(v[i].op, v[i].a, v[i].b);
      wait_rsp(n);
      chk($sformatf("seq%0d_result", i), bus.rsp_result, v[i].res);
      chk($sformatf("seq%0d_err", i), bus.rsp_err, v[i].err);
      tick();
    end
`ifdef ALU_REQ_ISSUER_STATS_EN
    chk("stat_cmds", stat_cmds, 4);
    chk("stat_errs", stat_errs, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
